// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction fetch front end. Walks the PC, requests words from the
//   instruction cache, and statically predicts JAL targets. Fetched words are
//   stored in a first-word-fall-through queue that feeds the decoder. A
//   redirect from the branch/commit unit flushes the queue and any in-flight
//   fetch.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   rdy             global ready, all state freezes while low
//   ic_req/ic_addr  level fetch request and word-aligned address to the cache
//   ic_ready/ic_inst cache response strobe and returned instruction word
//   br_valid/br_target redirect strobe and redirect PC
//   iq_valid/iq_inst/iq_pc/iq_pred_taken  queue head presented to the decoder
//   iq_pop          decoder consumes the head this cycle
module inst_fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_ready,
  input  logic [31:0] ic_inst,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic        iq_pred_taken,
  input  logic        iq_pop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     inst_mem_d [DEPTH];
  logic [31:0]     pc_mem_q   [DEPTH];
  logic [31:0]     pc_mem_d   [DEPTH];
  logic            pred_mem_q [DEPTH];
  logic            pred_mem_d [DEPTH];

  logic            push;
  logic            pop;
  logic            is_jal;
  logic [31:0]     j_imm;

  // The request uses the registered count, so a pop on a full queue only
  // re-opens fetching on the following cycle.
  assign ic_req   = (state_q == FETCH) && (count_q != CW'(DEPTH));
  assign ic_addr  = pc_q;
  assign iq_valid = (count_q != '0);

  // Head fields read as zero when nothing is queued so stale entries never
  // leak onto the decoder interface.
  assign iq_inst       = iq_valid ? inst_mem_q[head_q] : 32'h0;
  assign iq_pc         = iq_valid ? pc_mem_q[head_q]   : 32'h0;
  assign iq_pred_taken = iq_valid ? pred_mem_q[head_q] : 1'b0;

  assign is_jal = (ic_inst[6:0] == 7'b1101111);
  assign j_imm  = {{11{ic_inst[31]}}, ic_inst[31], ic_inst[19:12], ic_inst[20],
                   ic_inst[30:21], 1'b0};

  // A redirect outranks both the cache response and the decoder pop.
  assign push = rdy && !br_valid && ic_req && ic_ready;
  assign pop  = rdy && !br_valid && iq_pop && iq_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    pred_mem_d = pred_mem_q;

    if (rdy) begin
      if (br_valid) begin
        state_d = FLUSH;
        pc_d    = {br_target[31:2], 2'b00};
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        state_d = FETCH;
        if (push) begin
          inst_mem_d[tail_q] = ic_inst;
          pc_mem_d[tail_q]   = pc_q;
          pred_mem_d[tail_q] = is_jal;
          tail_d             = tail_q + PW'(1);
          pc_d               = is_jal ? (pc_q + j_imm) : (pc_q + 32'd4);
        end
        if (pop) begin
          head_d = head_q + PW'(1);
        end
        case ({push, pop})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: the head fields are masked while empty.
  always_ff @(posedge clk) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
    pred_mem_q <= pred_mem_d;
  end

endmodule
